// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR owner and SRAM access sequencer; a read completes WAIT_STATES edges after the request, a write one edge later.
// Requests and register loads are only accepted in IDLE, so the datapath must wait for the Mem_Ready pulse.
module lc3_mem_ctrl #(
   parameter int WAIT_STATES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] Bus_In,
   input  logic        LD_MAR,
   input  logic        LD_MDR,
   input  logic        Mem_Req,
   input  logic        Mem_WE,
   input  logic [15:0] Data_From_SRAM,
   output logic [15:0] MAR,
   output logic [15:0] MDR,
   output logic [15:0] ADDR,
   output logic [15:0] Data_To_SRAM,
   output logic        Data_Drive,
   output logic        CE_N,
   output logic        OE_N,
   output logic        WE_N,
   output logic        Busy,
   output logic        Mem_Ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_WREC,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_STATES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [15:0] r_mar;
   logic [15:0] w_mar_nxt;
   logic [15:0] r_mdr;
   logic [15:0] w_mdr_nxt;

   logic r_ce_n, r_oe_n, r_we_n, r_drive, r_busy, r_ready;
   logic w_ce_n, w_oe_n, w_we_n, w_drive, w_busy, w_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mar_nxt   = r_mar;
      w_mdr_nxt   = r_mdr;
      case (r_state)
         S_IDLE: begin
            if (LD_MAR) w_mar_nxt = Bus_In;
            if (LD_MDR) w_mdr_nxt = Bus_In;
            if (Mem_Req) begin
               w_state_nxt = Mem_WE ? S_WR : S_RD;
               w_cnt_nxt   = LP_CNT_LOAD;
            end
         end
         S_RD: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_mdr_nxt   = Data_From_SRAM;
               w_state_nxt = S_DONE;
            end
         end
         S_WR: begin
            if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
            else               w_state_nxt = S_WREC;
         end
         S_WREC:  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state and registered, so the SRAM pins never glitch on decode.
   always_comb begin
      w_ce_n  = 1'b1;
      w_oe_n  = 1'b1;
      w_we_n  = 1'b1;
      w_drive = 1'b0;
      w_busy  = 1'b0;
      w_ready = 1'b0;
      case (w_state_nxt)
         S_RD: begin
            w_ce_n = 1'b0;
            w_oe_n = 1'b0;
            w_busy = 1'b1;
         end
         S_WR: begin
            w_ce_n  = 1'b0;
            w_we_n  = 1'b0;
            w_drive = 1'b1;
            w_busy  = 1'b1;
         end
         S_WREC: begin
            w_ce_n  = 1'b0;
            w_drive = 1'b1;
            w_busy  = 1'b1;
         end
         S_DONE:  w_ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_mar   <= 16'h0000;
         r_mdr   <= 16'h0000;
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_drive <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mar   <= w_mar_nxt;
         r_mdr   <= w_mdr_nxt;
         r_ce_n  <= w_ce_n;
         r_oe_n  <= w_oe_n;
         r_we_n  <= w_we_n;
         r_drive <= w_drive;
         r_busy  <= w_busy;
         r_ready <= w_ready;
      end
   end

   assign MAR          = r_mar;
   assign MDR          = r_mdr;
   assign ADDR         = r_mar;
   assign Data_To_SRAM = r_mdr;
   assign Data_Drive   = r_drive;
   assign CE_N         = r_ce_n;
   assign OE_N         = r_oe_n;
   assign WE_N         = r_we_n;
   assign Busy         = r_busy;
   assign Mem_Ready    = r_ready;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: three instances (W=2, 1, 15) on one clock, each tracked by a
// transaction-timeline model (cycles elapsed since the request edge).
module tb_lc3_mem_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0][15:0] bus_in, sram_in, mar_o, mdr_o, addr_o, dts_o;
   logic [2:0] ld_mar, ld_mdr, req, we;
   logic [2:0] drv, ce_n, oe_n, we_n, busy, rdy;

   lc3_mem_ctrl #(.WAIT_STATES(2)) u_w2 (
      .Clk(clk), .Reset(rst), .Bus_In(bus_in[0]), .LD_MAR(ld_mar[0]), .LD_MDR(ld_mdr[0]),
      .Mem_Req(req[0]), .Mem_WE(we[0]), .Data_From_SRAM(sram_in[0]), .MAR(mar_o[0]),
      .MDR(mdr_o[0]), .ADDR(addr_o[0]), .Data_To_SRAM(dts_o[0]), .Data_Drive(drv[0]),
      .CE_N(ce_n[0]), .OE_N(oe_n[0]), .WE_N(we_n[0]), .Busy(busy[0]), .Mem_Ready(rdy[0]));
   lc3_mem_ctrl #(.WAIT_STATES(1)) u_w1 (
      .Clk(clk), .Reset(rst), .Bus_In(bus_in[1]), .LD_MAR(ld_mar[1]), .LD_MDR(ld_mdr[1]),
      .Mem_Req(req[1]), .Mem_WE(we[1]), .Data_From_SRAM(sram_in[1]), .MAR(mar_o[1]),
      .MDR(mdr_o[1]), .ADDR(addr_o[1]), .Data_To_SRAM(dts_o[1]), .Data_Drive(drv[1]),
      .CE_N(ce_n[1]), .OE_N(oe_n[1]), .WE_N(we_n[1]), .Busy(busy[1]), .Mem_Ready(rdy[1]));
   lc3_mem_ctrl #(.WAIT_STATES(15)) u_w15 (
      .Clk(clk), .Reset(rst), .Bus_In(bus_in[2]), .LD_MAR(ld_mar[2]), .LD_MDR(ld_mdr[2]),
      .Mem_Req(req[2]), .Mem_WE(we[2]), .Data_From_SRAM(sram_in[2]), .MAR(mar_o[2]),
      .MDR(mdr_o[2]), .ADDR(addr_o[2]), .Data_To_SRAM(dts_o[2]), .Data_Drive(drv[2]),
      .CE_N(ce_n[2]), .OE_N(oe_n[2]), .WE_N(we_n[2]), .Busy(busy[2]), .Mem_Ready(rdy[2]));

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: m_t = edges since the accepting edge (-1 when idle).
   int          wv [3];
   int          m_t [3];
   bit          m_wr [3];
   logic [15:0] m_mar [3];
   logic [15:0] m_mdr [3];

   typedef struct packed {
      logic        ld_mar, ld_mdr, req, we;
      logic [15:0] bus, sram;
      logic [5:0]  ctl;
      logic [15:0] mar, mdr;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [69:0] a, input logic [69:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
      end
   endtask

   function automatic logic [69:0] act(input int k);
      return {ce_n[k], oe_n[k], we_n[k], drv[k], busy[k], rdy[k],
              mar_o[k], mdr_o[k], addr_o[k], dts_o[k]};
   endfunction

   function automatic logic [5:0] exp_ctl(input int k);
      int t;
      int w;
      t = m_t[k];
      w = wv[k];
      if (t < 0) return 6'b111000;
      if (!m_wr[k]) return (t < w) ? 6'b001010 : 6'b111001;
      if (t < w) return 6'b010110;
      if (t == w) return 6'b011110;
      return 6'b111001;
   endfunction

   function automatic logic [69:0] exp_out(input int k);
      return {exp_ctl(k), m_mar[k], m_mdr[k], m_mar[k], m_mdr[k]};
   endfunction

   task automatic model_reset(input int k);
      m_t[k]   = -1;
      m_wr[k]  = 1'b0;
      m_mar[k] = 16'h0000;
      m_mdr[k] = 16'h0000;
   endtask

   task automatic model_step(input int k);
      if (rst) begin
         model_reset(k);
      end else if (m_t[k] < 0) begin
         if (ld_mar[k]) m_mar[k] = bus_in[k];
         if (ld_mdr[k]) m_mdr[k] = bus_in[k];
         if (req[k]) begin
            m_t[k]  = 0;
            m_wr[k] = we[k];
         end
      end else begin
         m_t[k]++;
         if (!m_wr[k] && m_t[k] == wv[k]) m_mdr[k] = sram_in[k];
         if (m_t[k] == wv[k] + 1 + int'(m_wr[k])) m_t[k] = -1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("model_w%0d", wv[k]), act(k), exp_out(k));
   endtask

   task automatic set_in(input int k, input bit lm, input bit ld, input bit rq, input bit w,
                         input logic [15:0] b, input logic [15:0] s);
      ld_mar[k]  = lm;
      ld_mdr[k]  = ld;
      req[k]     = rq;
      we[k]      = w;
      bus_in[k]  = b;
      sram_in[k] = s;
   endtask

   task automatic idle_in(input int k);
      set_in(k, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int e;
      int p0;
      int p1;
      logic [15:0] s;

      wv[0] = 2; wv[1] = 1; wv[2] = 15;
      for (int k = 0; k < 3; k++) begin
         model_reset(k);
         idle_in(k);
      end

      // Reset values
      rst = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 3; k++) chk("reset_vals", act(k), {6'b111000, 64'h0});
      rst = 1'b0;

      // Directed read then write on W=2, cycle by cycle
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 6'b111000, 16'h1234, 16'h0000};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 6'b001010, 16'h1234, 16'h0000};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 6'b001010, 16'h1234, 16'h0000};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 6'b111001, 16'h1234, 16'hBEEF};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'b111000, 16'h1234, 16'hBEEF};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 6'b111000, 16'h3000, 16'hBEEF};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5, 16'h0000, 6'b010110, 16'h3000, 16'hA5A5};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'b010110, 16'h3000, 16'hA5A5};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'b011110, 16'h3000, 16'hA5A5};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'b111001, 16'h3000, 16'hA5A5};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'b111000, 16'h3000, 16'hA5A5};
      for (int i = 0; i < 11; i++) begin
         set_in(0, tbl[i].ld_mar, tbl[i].ld_mdr, tbl[i].req, tbl[i].we, tbl[i].bus, tbl[i].sram);
         tick();
         chk($sformatf("table_%0d", i), act(0),
             {tbl[i].ctl, tbl[i].mar, tbl[i].mdr, tbl[i].mar, tbl[i].mdr});
      end
      idle_in(0);

      // Busy lockout: loads and requests during a read are ignored
      s = 16'($urandom);
      set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h0000);
      tick();
      cnt = 0;
      set_in(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, s);
      tick(); cnt += int'(rdy[0]);
      set_in(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, s);
      tick(); cnt += int'(rdy[0]);
      set_in(0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, s);
      tick(); cnt += int'(rdy[0]);
      idle_in(0);
      for (int i = 0; i < 4; i++) begin
         tick(); cnt += int'(rdy[0]);
      end
      chk("lockout_ready_pulses", 70'(cnt), 70'd1);
      chk("lockout_mar", 70'(mar_o[0]), 70'h4321);
      chk("lockout_mdr", 70'(mdr_o[0]), 70'(s));

      // Back-to-back reads with Mem_Req held high
      p0 = -1; p1 = -1;
      set_in(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'($urandom));
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rdy[0] && p0 < 0) p0 = i;
         else if (rdy[0] && p1 < 0) p1 = i;
      end
      idle_in(0);
      for (int i = 0; i < 4; i++) tick();
      chk("b2b_first_ready_edge", 70'(p0), 70'd2);
      chk("b2b_ready_gap_cycles", 70'(p1 - p0 - 1), 70'd3);

      // Reset during the first WR cycle
      set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0000);
      tick();
      set_in(0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h6666, 16'h0000);
      tick();
      idle_in(0);
      chk("pre_reset_write_active", 70'({we_n[0], drv[0]}), 70'b01);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", act(0), {6'b111000, 64'h0});
      for (int k = 0; k < 3; k++) model_reset(k);
      tick();
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick(); cnt += int'(rdy[0]);
      end
      chk("reset_no_ready", 70'(cnt), 70'd0);
      s = 16'($urandom);
      set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000);
      tick();
      set_in(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, s);
      tick();
      set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, s);
      e = 0;
      while (!rdy[0] && e < 40) begin
         tick(); e++;
      end
      chk("post_reset_read_edge", 70'(e), 70'd2);
      chk("post_reset_read_mdr", 70'(mdr_o[0]), 70'(s));
      idle_in(0);
      tick();

      // W=1 and W=15 completion edges
      for (int k = 1; k < 3; k++) begin
         for (int w = 0; w < 2; w++) begin
            s = 16'($urandom);
            set_in(k, 1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'h0000);
            tick();
            set_in(k, 1'b0, 1'b1, 1'b1, w[0], 16'($urandom), s);
            tick();
            set_in(k, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, s);
            e = 0;
            while (!rdy[k] && e < 40) begin
               tick(); e++;
            end
            chk($sformatf("sweep_w%0d_%s_edge", wv[k], w ? "wr" : "rd"),
                70'(e), 70'(wv[k] + w));
            idle_in(k);
            tick();
            tick();
         end
      end

      // Randomized traffic on all instances
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 3; k++)
            set_in(k, ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                   1'($urandom), 16'($urandom), 16'($urandom));
         rst = (($urandom % 150) == 0);
         tick();
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) idle_in(k);
      for (int i = 0; i < 20; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
